mux_scan_sequencer: RTL and testbench



---
 rtl/mux_scan_sequencer_pkg.sv | 18 +
 rtl/mux_scan_sequencer_scan_index_counter.sv | 45 ++++
 rtl/mux_scan_sequencer.sv | 96 +++++++++
 tb/tb_mux_scan_sequencer.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mux_scan_sequencer_pkg.sv
// Shared types and scan-order helpers for the mux scan sequencer and its index counter.
package mux_scan_sequencer_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_e;

    // First index presented for a word: 0 for LSB-first, N-1 for MSB-first.
    function automatic int unsigned scan_start(input int unsigned k, input bit msb_first);
        return msb_first ? ((32'd1 << k) - 32'd1) : 32'd0;
    endfunction

    function automatic int unsigned scan_end(input int unsigned k, input bit msb_first);
        return msb_first ? 32'd0 : ((32'd1 << k) - 32'd1);
    endfunction

endpackage

// File: rtl/mux_scan_sequencer_scan_index_counter.sv
// K-bit loadable up/down counter that walks the mux select from the scan start to the scan end.
module scan_index_counter
    import mux_scan_sequencer_pkg::*;
#(
    parameter int unsigned K         = 2,
    parameter bit          MSB_FIRST = 1'b0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         step,
    input  logic         dir,
    output logic [K-1:0] idx,
    output logic         at_end
);

    localparam logic [K-1:0] START = K'(scan_start(K, MSB_FIRST));
    localparam logic [K-1:0] END   = K'(scan_end(K, MSB_FIRST));
    localparam logic [K-1:0] ONE   = K'(1);

    logic [K-1:0] idx_q;
    logic [K-1:0] idx_d;

    // load wins over step so a new word always restarts at the scan start.
    always_comb begin
        idx_d = idx_q;
        if (load) begin
            idx_d = START;
        end else if (step) begin
            idx_d = dir ? (idx_q - ONE) : (idx_q + ONE);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q <= START;
        end else begin
            idx_q <= idx_d;
        end
    end

    assign idx    = idx_q;
    assign at_end = (idx_q == END);

endmodule

// File: rtl/mux_scan_sequencer.sv
// Holds a parallel word on an external bit-select mux and scans its select to emit a framed serial stream.
module mux_scan_sequencer
    import mux_scan_sequencer_pkg::*;
#(
    parameter  int unsigned K         = 2,
    parameter  bit          MSB_FIRST = 1'b0,
    localparam int unsigned N         = 2 ** K
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_data,
    output logic [N-1:0] mux_in,
    output logic [K-1:0] mux_sel,
    input  logic         mux_out,
    output logic         bit_valid,
    output logic         bit_data,
    output logic         bit_first,
    output logic         bit_last,
    input  logic         bit_ready,
    output logic         busy
);

    localparam logic [K-1:0] START = K'(scan_start(K, MSB_FIRST));

    state_e       state_q;
    state_e       state_d;
    logic [N-1:0] mux_in_q;
    logic [N-1:0] mux_in_d;
    logic         cnt_load;
    logic         cnt_step;
    logic         at_end;
    logic [K-1:0] sel;
    logic         scanning;
    logic         last_taken;
    logic         ready_c;

    scan_index_counter #(
        .K         (K),
        .MSB_FIRST (MSB_FIRST)
    ) u_index (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (cnt_load),
        .step   (cnt_step),
        .dir    (MSB_FIRST),
        .idx    (sel),
        .at_end (at_end)
    );

    assign scanning   = (state_q == SCAN);
    assign last_taken = scanning && bit_ready && at_end;

    // flush outranks every handshake; the end check precedes any step so the index never wraps.
    always_comb begin
        state_d  = state_q;
        mux_in_d = mux_in_q;
        cnt_load = 1'b0;
        cnt_step = 1'b0;
        ready_c  = rst_n && !flush && ((state_q == IDLE) || last_taken);
        if (flush) begin
            state_d  = IDLE;
            cnt_load = 1'b1;
        end else if (in_valid && ready_c) begin
            state_d  = SCAN;
            mux_in_d = in_data;
            cnt_load = 1'b1;
        end else if (last_taken) begin
            state_d  = IDLE;
        end else if (scanning && bit_ready) begin
            cnt_step = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            mux_in_q <= '0;
        end else begin
            state_q  <= state_d;
            mux_in_q <= mux_in_d;
        end
    end

    assign in_ready  = ready_c;
    assign mux_in    = mux_in_q;
    assign mux_sel   = sel;
    assign bit_valid = scanning;
    assign bit_data  = mux_out;
    assign bit_first = scanning && (sel == START);
    assign bit_last  = scanning && at_end;
    assign busy      = scanning;

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Two sequencer instances (K=2 LSB-first, K=3 MSB-first) driven by directed and random traffic against a word-level model.
module tb_mux_scan_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] flush;
    logic [1:0] in_valid;
    logic [1:0] bit_ready;
    logic [7:0] in_data [2];

    wire        in_ready_a, bit_valid_a, bit_data_a, bit_first_a, bit_last_a, busy_a;
    wire        in_ready_b, bit_valid_b, bit_data_b, bit_first_b, bit_last_b, busy_b;
    wire  [3:0] mux_in_a;
    wire  [1:0] sel_a;
    wire  [7:0] mux_in_b;
    wire  [2:0] sel_b;
    wire        mux_out_a;
    wire        mux_out_b;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    assign mux_out_a = mux_in_a[sel_a];
    assign mux_out_b = mux_in_b[sel_b];

    mux_scan_sequencer #(.K(2), .MSB_FIRST(1'b0)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .flush(flush[0]),
        .in_valid(in_valid[0]), .in_ready(in_ready_a), .in_data(in_data[0][3:0]),
        .mux_in(mux_in_a), .mux_sel(sel_a), .mux_out(mux_out_a),
        .bit_valid(bit_valid_a), .bit_data(bit_data_a), .bit_first(bit_first_a),
        .bit_last(bit_last_a), .bit_ready(bit_ready[0]), .busy(busy_a)
    );

    mux_scan_sequencer #(.K(3), .MSB_FIRST(1'b1)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .flush(flush[1]),
        .in_valid(in_valid[1]), .in_ready(in_ready_b), .in_data(in_data[1]),
        .mux_in(mux_in_b), .mux_sel(sel_b), .mux_out(mux_out_b),
        .bit_valid(bit_valid_b), .bit_data(bit_data_b), .bit_first(bit_first_b),
        .bit_last(bit_last_b), .bit_ready(bit_ready[1]), .busy(busy_b)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Word-level model: a word is N bits delivered in scan order; pos counts bits already taken.
    logic       m_act  [2];
    int         m_pos  [2];
    logic [7:0] m_word [2];
    int         m_isel [2];

    function automatic int nb(input int u);
        return (u == 0) ? 4 : 8;
    endfunction

    function automatic int start_of(input int u);
        return (u == 0) ? 0 : 7;
    endfunction

    function automatic int end_of(input int u);
        return (u == 0) ? 3 : 0;
    endfunction

    function automatic int bidx(input int u);
        return (u == 0) ? m_pos[0] : (7 - m_pos[1]);
    endfunction

    function automatic logic exp_rdy(input int u);
        return rst_n && !flush[u] && (!m_act[u] || (bit_ready[u] && (m_pos[u] == nb(u) - 1)));
    endfunction

    always @(posedge clk or negedge rst_n) begin
        for (int u = 0; u < 2; u++) begin
            if (!rst_n) begin
                m_act[u]  = 1'b0;
                m_pos[u]  = 0;
                m_word[u] = 8'h00;
                m_isel[u] = start_of(u);
            end else if (flush[u]) begin
                m_act[u]  = 1'b0;
                m_isel[u] = start_of(u);
            end else if (in_valid[u] && exp_rdy(u)) begin
                m_act[u]  = 1'b1;
                m_pos[u]  = 0;
                m_word[u] = (u == 0) ? (in_data[0] & 8'h0F) : in_data[1];
            end else if (m_act[u] && bit_ready[u]) begin
                if (m_pos[u] == nb(u) - 1) begin
                    m_act[u]  = 1'b0;
                    m_isel[u] = end_of(u);
                end else begin
                    m_pos[u]++;
                end
            end
        end
    end

    always @(negedge clk) begin
        for (int u = 0; u < 2; u++) begin
            logic        a_valid, a_ready, a_busy, a_data, a_first, a_last;
            logic [31:0] a_sel, a_mux;
            int          idx;
            a_valid = (u == 0) ? bit_valid_a : bit_valid_b;
            a_ready = (u == 0) ? in_ready_a  : in_ready_b;
            a_busy  = (u == 0) ? busy_a      : busy_b;
            a_data  = (u == 0) ? bit_data_a  : bit_data_b;
            a_first = (u == 0) ? bit_first_a : bit_first_b;
            a_last  = (u == 0) ? bit_last_a  : bit_last_b;
            a_sel   = (u == 0) ? 32'(sel_a)    : 32'(sel_b);
            a_mux   = (u == 0) ? 32'(mux_in_a) : 32'(mux_in_b);
            idx     = bidx(u);
            chk($sformatf("u%0d_valid", u), 32'(a_valid), 32'(m_act[u]));
            chk($sformatf("u%0d_in_ready", u), 32'(a_ready), 32'(exp_rdy(u)));
            chk($sformatf("u%0d_busy", u), 32'(a_busy), 32'(m_act[u]));
            chk($sformatf("u%0d_mux_in", u), a_mux, 32'(m_word[u]));
            chk($sformatf("u%0d_sel", u), a_sel, m_act[u] ? 32'(idx) : 32'(m_isel[u]));
            if (m_act[u]) begin
                chk($sformatf("u%0d_data", u), 32'(a_data), 32'(m_word[u][idx]));
                chk($sformatf("u%0d_first", u), 32'(a_first), 32'(m_pos[u] == 0));
                chk($sformatf("u%0d_last", u), 32'(a_last), 32'(m_pos[u] == nb(u) - 1));
            end else begin
                chk($sformatf("u%0d_first_idle", u), 32'(a_first), 32'd0);
                chk($sformatf("u%0d_last_idle", u), 32'(a_last), 32'd0);
            end
        end
    end

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        flush      = 2'b00;
        in_valid   = 2'b00;
        bit_ready  = 2'b00;
        in_data[0] = 8'h00;
        in_data[1] = 8'h00;
        step(3);
        rst_n = 1'b1;
        step(1);

        // Basic LSB-first scan of 4'b1011.
        bit_ready  = 2'b11;
        in_valid   = 2'b01;
        in_data[0] = 8'h0B;
        step(1);
        in_valid = 2'b00;
        step(5);

        // Backpressure at select 2.
        in_valid = 2'b01;
        step(1);
        in_valid = 2'b00;
        step(2);
        bit_ready = 2'b00;
        step(3);
        bit_ready = 2'b11;
        step(4);

        // Back-to-back 4'hA then 4'h5 with in_valid held high.
        in_valid   = 2'b01;
        in_data[0] = 8'h0A;
        step(1);
        in_data[0] = 8'h05;
        step(4);
        in_valid = 2'b00;
        step(5);

        // MSB-first K=3 scan of 8'b1000_0001.
        in_valid   = 2'b10;
        in_data[1] = 8'h81;
        step(1);
        in_valid = 2'b00;
        step(10);

        // Flush at select 1 of 4'hF, then 4'h0.
        in_valid   = 2'b01;
        in_data[0] = 8'h0F;
        step(1);
        in_valid = 2'b00;
        step(1);
        flush = 2'b01;
        step(1);
        flush      = 2'b00;
        in_valid   = 2'b01;
        in_data[0] = 8'h00;
        step(1);
        in_valid = 2'b00;
        step(5);

        // Asynchronous reset mid-word, away from any clock edge.
        in_valid   = 2'b11;
        in_data[0] = 8'h0D;
        in_data[1] = 8'hC3;
        step(1);
        in_valid = 2'b00;
        step(2);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("rst_valid_a", 32'(bit_valid_a), 32'd0);
        chk("rst_ready_a", 32'(in_ready_a), 32'd0);
        chk("rst_busy_a", 32'(busy_a), 32'd0);
        chk("rst_sel_a", 32'(sel_a), 32'd0);
        chk("rst_mux_in_a", 32'(mux_in_a), 32'd0);
        chk("rst_sel_b", 32'(sel_b), 32'd7);
        chk("rst_valid_b", 32'(bit_valid_b), 32'd0);
        step(2);
        rst_n = 1'b1;
        #3;
        chk("post_rst_ready_a", 32'(in_ready_a), 32'd1);
        chk("post_rst_ready_b", 32'(in_ready_b), 32'd1);
        step(1);

        // Random traffic on both instances.
        for (int c = 0; c < 4000; c++) begin
            for (int u = 0; u < 2; u++) begin
                flush[u]     = ($urandom_range(0, 31) == 0);
                in_valid[u]  = $urandom_range(0, 1) == 1;
                bit_ready[u] = ($urandom_range(0, 9) < 7);
                in_data[u]   = 8'($urandom);
            end
            step(1);
        end
        flush    = 2'b00;
        in_valid = 2'b00;
        bit_ready = 2'b11;
        step(10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
